// File: rtl/and16_checker.sv
// Response monitor for the 16-bit AND datapath: counts matches and mismatches, reports a verdict.
// Define CHECKER_FIRST_FAIL_EN to build the first-fail capture registers.
module and16_checker #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned EXPECT_COUNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             ff_valid,
   output logic [CNT_W-1:0] ff_idx,
   output logic [WIDTH-1:0] ff_a,
   output logic [WIDTH-1:0] ff_b,
   output logic [WIDTH-1:0] ff_out
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(EXPECT_COUNT - 1);
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

   state_e           r_state;
   state_e           w_state_d;
   logic [CNT_W-1:0] r_pass_cnt;
   logic [CNT_W-1:0] r_fail_cnt;
   logic [CNT_W-1:0] r_idx;
   logic             w_accept;
   logic             w_match;
   logic             w_clear;

   assign w_accept = in_valid && (r_state == StRun);
   assign w_match  = (in_out == (in_a & in_b));
   // start is honoured only outside RUN
   assign w_clear  = start && (r_state != StRun);

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (start) w_state_d = StRun;
         StRun:   if (w_accept && (r_idx == LastIdx)) w_state_d = StDone;
         StDone:  if (start) w_state_d = StRun;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_pass_cnt <= '0;
         r_fail_cnt <= '0;
         r_idx      <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_clear) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_idx      <= '0;
         end else if (w_accept) begin
            r_idx <= r_idx + 1'b1;
            if (w_match) begin
               if (r_pass_cnt != CntMax) r_pass_cnt <= r_pass_cnt + 1'b1;
            end else begin
               if (r_fail_cnt != CntMax) r_fail_cnt <= r_fail_cnt + 1'b1;
            end
         end
      end
   end

`ifdef CHECKER_FIRST_FAIL_EN
   logic             r_ff_valid;
   logic [CNT_W-1:0] r_ff_idx;
   logic [WIDTH-1:0] r_ff_a;
   logic [WIDTH-1:0] r_ff_b;
   logic [WIDTH-1:0] r_ff_out;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ff_valid <= 1'b0;
         r_ff_idx   <= '0;
         r_ff_a     <= '0;
         r_ff_b     <= '0;
         r_ff_out   <= '0;
      end else if (w_clear) begin
         r_ff_valid <= 1'b0;
         r_ff_idx   <= '0;
         r_ff_a     <= '0;
         r_ff_b     <= '0;
         r_ff_out   <= '0;
      end else if (w_accept && !w_match && !r_ff_valid) begin
         r_ff_valid <= 1'b1;
         r_ff_idx   <= r_idx;
         r_ff_a     <= in_a;
         r_ff_b     <= in_b;
         r_ff_out   <= in_out;
      end
   end

   assign ff_valid = r_ff_valid;
   assign ff_idx   = r_ff_idx;
   assign ff_a     = r_ff_a;
   assign ff_b     = r_ff_b;
   assign ff_out   = r_ff_out;
`else
   assign ff_valid = 1'b0;
   assign ff_idx   = '0;
   assign ff_a     = '0;
   assign ff_b     = '0;
   assign ff_out   = '0;
`endif

   assign in_ready = (r_state == StRun);
   assign busy     = (r_state == StRun);
   assign done     = (r_state == StDone);
   assign pass     = (r_state == StDone) && (r_fail_cnt == '0);
   assign pass_cnt = r_pass_cnt;
   assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_and16_checker.sv
// Directed bench for and16_checker with EXPECT_COUNT=4; first-fail expectations follow
// CHECKER_FIRST_FAIL_EN.
module tb_and16_checker;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [15:0] in_out;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] pass_cnt;
   logic [15:0] fail_cnt;
   logic        ff_valid;
   logic [15:0] ff_idx;
   logic [15:0] ff_a;
   logic [15:0] ff_b;
   logic [15:0] ff_out;

   int total = 0;
   int bad   = 0;

   and16_checker #(
      .WIDTH       (16),
      .CNT_W       (16),
      .EXPECT_COUNT(4)
   ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_a    (in_a),
      .in_b    (in_b),
      .in_out  (in_out),
      .busy    (busy),
      .done    (done),
      .pass    (pass),
      .pass_cnt(pass_cnt),
      .fail_cnt(fail_cnt),
      .ff_valid(ff_valid),
      .ff_idx  (ff_idx),
      .ff_a    (ff_a),
      .ff_b    (ff_b),
      .ff_out  (ff_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [15:0] o);
      in_a     = a;
      in_b     = b;
      in_out   = o;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
      check({pfx, "_busy"}, 32'(busy), 32'd0);
      check({pfx, "_done"}, 32'(done), 32'd0);
      check({pfx, "_pass"}, 32'(pass), 32'd0);
      check({pfx, "_pass_cnt"}, 32'(pass_cnt), 32'd0);
      check({pfx, "_fail_cnt"}, 32'(fail_cnt), 32'd0);
      check({pfx, "_ff_valid"}, 32'(ff_valid), 32'd0);
      check({pfx, "_ff_idx"}, 32'(ff_idx), 32'd0);
      check({pfx, "_ff_a"}, 32'(ff_a), 32'd0);
      check({pfx, "_ff_out"}, 32'(ff_out), 32'd0);
   endtask

   task automatic four_matches();
      beat(16'h0000, 16'h0000, 16'h0000);
      beat(16'h0000, 16'hFFFF, 16'h0000);
      beat(16'hFFFF, 16'h0000, 16'h0000);
      beat(16'hFFFF, 16'hFFFF, 16'hFFFF);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_out   = '0;
      step();
      step();
      check_reset_vals("rst");
      rst_n = 1'b1;

      // Valid beats in IDLE are dropped.
      in_a = 16'h00FF; in_b = 16'h0F0F; in_out = 16'h000F; in_valid = 1'b1;
      step();
      step();
      in_valid = 1'b0;
      check("idle_drop_pass_cnt", 32'(pass_cnt), 32'd0);
      check("idle_drop_ready", 32'(in_ready), 32'd0);

      // All-match run.
      pulse_start();
      check("run1_ready", 32'(in_ready), 32'd1);
      check("run1_busy", 32'(busy), 32'd1);
      beat(16'h0000, 16'h0000, 16'h0000);
      check("run1_lat_pass_cnt", 32'(pass_cnt), 32'd1);
      beat(16'h0000, 16'hFFFF, 16'h0000);
      beat(16'hFFFF, 16'h0000, 16'h0000);
      check("run1_not_done", 32'(done), 32'd0);
      beat(16'hFFFF, 16'hFFFF, 16'hFFFF);
      check("run1_done", 32'(done), 32'd1);
      check("run1_busy_low", 32'(busy), 32'd0);
      check("run1_ready_low", 32'(in_ready), 32'd0);
      check("run1_pass_cnt", 32'(pass_cnt), 32'd4);
      check("run1_fail_cnt", 32'(fail_cnt), 32'd0);
      check("run1_pass", 32'(pass), 32'd1);
      check("run1_ff_valid", 32'(ff_valid), 32'd0);

      // Valid beats in DONE are dropped.
      in_a = 16'h1111; in_b = 16'h1111; in_out = 16'h0000; in_valid = 1'b1;
      step();
      step();
      in_valid = 1'b0;
      check("done_drop_pass_cnt", 32'(pass_cnt), 32'd4);
      check("done_drop_fail_cnt", 32'(fail_cnt), 32'd0);
      check("done_hold", 32'(done), 32'd1);

      // Restart from DONE clears, then mismatch-capture run.
      pulse_start();
      check("rs_pass_cnt", 32'(pass_cnt), 32'd0);
      check("rs_ready", 32'(in_ready), 32'd1);
      check("rs_done", 32'(done), 32'd0);
      beat(16'h0001, 16'h0000, 16'h0000);
      beat(16'h0001, 16'h0001, 16'h0000);
      beat(16'h00F0, 16'h0FF0, 16'h0000);
      beat(16'h1234, 16'hFFFF, 16'h1234);
      check("mm_done", 32'(done), 32'd1);
      check("mm_pass_cnt", 32'(pass_cnt), 32'd2);
      check("mm_fail_cnt", 32'(fail_cnt), 32'd2);
      check("mm_pass", 32'(pass), 32'd0);
`ifdef CHECKER_FIRST_FAIL_EN
      check("mm_ff_valid", 32'(ff_valid), 32'd1);
      check("mm_ff_idx", 32'(ff_idx), 32'd1);
      check("mm_ff_a", 32'(ff_a), 32'h0001);
      check("mm_ff_b", 32'(ff_b), 32'h0001);
      check("mm_ff_out", 32'(ff_out), 32'h0000);
`else
      check("mm_ff_valid", 32'(ff_valid), 32'd0);
      check("mm_ff_idx", 32'(ff_idx), 32'd0);
      check("mm_ff_a", 32'(ff_a), 32'd0);
`endif

      // Start clears capture; gaps of 3 idle cycles between beats.
      pulse_start();
      check("gap_ff_valid_clr", 32'(ff_valid), 32'd0);
      check("gap_fail_clr", 32'(fail_cnt), 32'd0);
      for (int i = 0; i < 4; i++) begin
         beat(16'hA5A5, 16'h0FF0, 16'h05A0);
         check("gap_pass_cnt", 32'(pass_cnt), 32'(i + 1));
         if (i < 3) begin
            step();
            step();
            step();
            check("gap_not_done", 32'(done), 32'd0);
         end
      end
      check("gap_done", 32'(done), 32'd1);
      check("gap_pass", 32'(pass), 32'd1);

      // Reset mid-run after 2 beats, one of which mismatches.
      pulse_start();
      beat(16'h00FF, 16'h00FF, 16'h00FE);
      beat(16'h0F00, 16'hFF00, 16'h0F00);
      check("mr_fail_cnt", 32'(fail_cnt), 32'd1);
      rst_n    = 1'b0;
      start    = 1'b1;
      in_valid = 1'b1;
      step();
      rst_n    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      check_reset_vals("mr");
      pulse_start();
      four_matches();
      check("mr_pass", 32'(pass), 32'd1);
      check("mr_pass_cnt", 32'(pass_cnt), 32'd4);

      // Restart from DONE, then start during RUN is ignored.
      pulse_start();
      check("sr_ready", 32'(in_ready), 32'd1);
      check("sr_pass_cnt_clr", 32'(pass_cnt), 32'd0);
      beat(16'h8000, 16'h8001, 16'h8000);
      pulse_start();
      check("sr_pass_cnt_held", 32'(pass_cnt), 32'd1);
      check("sr_still_busy", 32'(busy), 32'd1);
      beat(16'h0003, 16'h0005, 16'h0001);
      beat(16'h7777, 16'h0000, 16'h0000);
      check("sr_not_done", 32'(done), 32'd0);
      beat(16'hFFFF, 16'h1234, 16'h1234);
      check("sr_done", 32'(done), 32'd1);
      check("sr_pass_cnt", 32'(pass_cnt), 32'd4);
      check("sr_pass", 32'(pass), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/and16_checker.md
# and16_checker

Self-checking response monitor for the 16-bit AND datapath. It consumes a valid/ready stream of observed (a, b, out) triples and recomputes the expected a & b for each one. It counts matches and mismatches, optionally latches the first failing vector, and reports a pass/fail verdict after a fixed number of vectors. It sits on the observation side of the gate test harness, opposite the stimulus driver, so regressions can run without waveform or $monitor inspection.

## Interface
Parameters:
- WIDTH, 16, data width of a, b, out
- CNT_W, 16, width of counters and vector index
- EXPECT_COUNT, 4, vectors to accept per run; legal range 1 to 2^CNT_W-1

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE
- in_valid  input  1  triple present on in_a/in_b/in_out
- in_ready  output  1  checker accepts a triple this cycle
- in_a  input  WIDTH  observed operand a
- in_b  input  WIDTH  observed operand b
- in_out  input  WIDTH  observed DUT output
- busy  output  1  state is RUN
- done  output  1  state is DONE
- pass  output  1  done and fail_cnt == 0
- pass_cnt  output  CNT_W  matching vectors this run
- fail_cnt  output  CNT_W  mismatching vectors this run
- ff_valid  output  1  first-fail capture holds data
- ff_idx  output  CNT_W  index (0-based) of first mismatch
- ff_a, ff_b, ff_out  output  WIDTH  triple of first mismatch

## Operation
- States: IDLE, RUN, DONE. Two-bit state register.
- IDLE: in_ready=0. A start pulse moves the block to RUN and clears pass_cnt, fail_cnt, idx, and all ff_* outputs.
- RUN: in_ready=1. A beat is accepted on each cycle with in_valid && in_ready.
  - On acceptance: match = (in_out == (in_a & in_b)) over all WIDTH bits.
  - A match increments pass_cnt; a mismatch increments fail_cnt.
  - idx increments on every acceptance.
  - The beat with idx == EXPECT_COUNT-1 moves the block to DONE.
- DONE: in_ready=0 and done=1. Counters hold. start returns the block to RUN and clears state as in IDLE.
- start during RUN is ignored; the run is not restarted.
- Counters saturate at all-ones and never wrap. idx cannot overflow because EXPECT_COUNT is bounded.
- in_valid without acceptance (IDLE, DONE) is dropped silently; no counter changes.
- Reset, including mid-run: state returns to IDLE. Outputs after reset: in_ready=0, busy=0, done=0, pass=0, all counters 0, ff_valid=0, all ff_* 0.

## Timing
- in_ready, busy, and done decode directly from the state register and are glitch-free relative to clk.
- A beat accepted at edge N is visible in pass_cnt/fail_cnt after edge N, i.e. 1-cycle latency.
- The last beat is accepted at edge N. After edge N, state=DONE, done=1, and pass is valid in the same cycle as the final counter update.
- start at edge N moves the state to RUN, so in_ready=1 from edge N onward. The first beat can be accepted at edge N+1.
- Throughput: one vector per cycle in RUN.
- rst_n low at an edge has priority over start and in_valid at that same edge.

## Configuration
- Macro CHECKER_FIRST_FAIL_EN.
- Defined: on the first mismatch of a run (ff_valid==0), the block latches ff_idx=idx, ff_a, ff_b, ff_out, and sets ff_valid=1. Later mismatches do not overwrite the capture. Capture is cleared by start and by reset.
- Undefined: no capture registers are built. ff_valid and all ff_* outputs are tied to 0. Counting and the verdict are unaffected.

## Test plan
- All-match run, EXPECT_COUNT=4: start, then feed (0000,0000,0000), (0000,FFFF,0000), (FFFF,0000,0000), (FFFF,FFFF,FFFF) on consecutive cycles -> done=1 one cycle after the 4th beat, pass_cnt=4, fail_cnt=0, pass=1, ff_valid=0.
- Mismatch capture (macro defined): feed (0001,0000,0000), (0001,0001,0000), (00F0,0FF0,0000), (1234,FFFF,1234) -> pass_cnt=2, fail_cnt=2, pass=0, ff_valid=1, ff_idx=1, ff_a=0001, ff_b=0001, ff_out=0000.
- Same stimulus, macro undefined -> fail_cnt=2, ff_valid=0, ff_idx=0.
- Backpressure/idle: hold in_valid=1 before start and after done -> no counter change. in_valid gaps of 3 cycles between beats in RUN -> counts unaffected, and done follows the 4th accepted beat.
- Reset mid-run: rst_n=0 after 2 accepted beats -> next cycle state IDLE with all outputs at reset values. A following start plus 4 matching beats -> pass=1, pass_cnt=4.
- Restart from DONE and start-in-RUN ignored: pulse start in DONE -> counters clear and in_ready=1. Pulse start again after 1 beat -> pass_cnt stays 1 and the run continues.
